demod_cordic_arbiter: RTL

- Time-shares one pipelined vectoring CORDIC between N_CH I/Q demodulation channels, each fed by its own IQ mixer.
- Grants one channel per cycle with round-robin arbitration and drives the CORDIC inputs.
- Tracks each in-flight sample with a channel tag through the fixed CORDIC latency.
- Returns magnitude (AM), phase (PM) and phase difference (FM) per channel, keeping per-channel previous-phase state.

---
 rtl/demod_cordic_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/demod_cordic_arbiter.sv
// Round-robin sharing of one pipelined vectoring CORDIC between N_CH I/Q channels, returning AM/PM/FM per channel.
// Optional macro DEMOD_ARB_STATS_EN adds per-channel maximum wait statistics (stat_wait_max).
module demod_cordic_arbiter #(
    parameter int N_CH    = 4,
    parameter int W       = 12,
    parameter int LATENCY = 18,
    parameter int TAG_W   = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic [N_CH-1:0]   ch_valid,
    output logic [N_CH-1:0]   ch_ready,
    input  logic [N_CH*W-1:0] ch_i,
    input  logic [N_CH*W-1:0] ch_q,
    input  logic [N_CH-1:0]   ch_clear,
    output logic [W-1:0]      cordic_x,
    output logic [W-1:0]      cordic_y,
    output logic              cordic_valid,
    input  logic [W-1:0]      cordic_mag,
    input  logic [W-1:0]      cordic_phase,
`ifdef DEMOD_ARB_STATS_EN
    output logic [8*N_CH-1:0] stat_wait_max,
`endif
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_ch,
    output logic [W-1:0]      out_am,
    output logic [W-1:0]      out_pm,
    output logic [W-1:0]      out_fm
);

    localparam logic [TAG_W-1:0] LAST_CH = TAG_W'(N_CH - 1);

    logic [TAG_W-1:0]   rr_ptr;
    logic               grant_any;
    logic [TAG_W-1:0]   grant_idx;
    logic [W-1:0]       sel_i;
    logic [W-1:0]       sel_q;
    logic               transfer;

    logic [TAG_W-1:0]   cordic_tag;
    logic [LATENCY-1:0] pipe_v;
    logic [TAG_W-1:0]   pipe_tag [LATENCY];
    logic               head_v;
    logic [TAG_W-1:0]   head_tag;
    logic               head_first;
    logic [W-1:0]       head_prev;

    logic [N_CH-1:0]    first_flag;
    logic [W-1:0]       prev [N_CH];

    // Search upward from rr_ptr first; if nothing is found there, wrap to the lowest requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_any && ch_valid[k] && (k >= int'(rr_ptr))) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(k);
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_any && ch_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(k);
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        sel_i    = '0;
        sel_q    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_any && (grant_idx == TAG_W'(k))) begin
                ch_ready[k] = en;
                sel_i       = ch_i[k*W +: W];
                sel_q       = ch_q[k*W +: W];
            end
        end
    end

    assign transfer = en & grant_any;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rr_ptr       <= '0;
            cordic_x     <= '0;
            cordic_y     <= '0;
            cordic_valid <= 1'b0;
            cordic_tag   <= '0;
        end else begin
            cordic_valid <= transfer;
            if (transfer) begin
                cordic_x   <= sel_i;
                cordic_y   <= sel_q;
                cordic_tag <= grant_idx;
                rr_ptr     <= (grant_idx == LAST_CH) ? '0 : grant_idx + TAG_W'(1);
            end
        end
    end

    // The tag line is fed from the registered CORDIC inputs, so its head meets the CORDIC output.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            pipe_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            pipe_v[0]   <= cordic_valid;
            pipe_tag[0] <= cordic_tag;
        end
    end

    assign head_v   = pipe_v[LATENCY-1];
    assign head_tag = pipe_tag[LATENCY-1];

    always_comb begin
        head_first = 1'b0;
        head_prev  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (head_tag == TAG_W'(k)) begin
                head_first = first_flag[k] | ch_clear[k];
                head_prev  = prev[k];
            end
        end
    end

    // A clear arriving with its own channel's result forces fm=0 but the stored phase becomes the new history.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_am     <= '0;
            out_pm     <= '0;
            out_fm     <= '0;
            first_flag <= '1;
            for (int k = 0; k < N_CH; k++) begin
                prev[k] <= '0;
            end
        end else begin
            out_valid <= head_v;
            if (head_v) begin
                out_ch <= head_tag;
                out_am <= cordic_mag;
                out_pm <= cordic_phase;
                out_fm <= head_first ? '0 : cordic_phase - head_prev;
            end
            for (int k = 0; k < N_CH; k++) begin
                if (head_v && (head_tag == TAG_W'(k))) begin
                    prev[k]       <= cordic_phase;
                    first_flag[k] <= 1'b0;
                end else if (ch_clear[k]) begin
                    first_flag[k] <= 1'b1;
                end
            end
        end
    end

`ifdef DEMOD_ARB_STATS_EN
    logic [7:0] wait_cnt [N_CH];
    logic [7:0] wait_nxt [N_CH];

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            wait_nxt[k] = '0;
            if (ch_valid[k] && !ch_ready[k]) begin
                wait_nxt[k] = (wait_cnt[k] == 8'hFF) ? 8'hFF : wait_cnt[k] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            stat_wait_max <= '0;
            for (int k = 0; k < N_CH; k++) begin
                wait_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                wait_cnt[k] <= wait_nxt[k];
                if (wait_nxt[k] > stat_wait_max[k*8 +: 8]) begin
                    stat_wait_max[k*8 +: 8] <= wait_nxt[k];
                end
            end
        end
    end
`endif

endmodule
